// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM timebase.
// Used by pwm_prescaler and pwm_timebase_ctrl.
package pwm_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PSC_W_DEF = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } cnt_dir_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: tick once every prescale+1 enabled cycles.
// A prescale below the running count lets it roll over through all-ones.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] prescale,
    output logic             tick
);

    localparam logic [PSC_W-1:0] ONE = 1;

    logic [PSC_W-1:0] r_psc_cnt;
    logic             w_match;

    // Terminal-count match qualifies the tick.
    always_comb begin
        w_match = (r_psc_cnt == prescale);
        tick    = en && w_match;
    end

    // Prescaler counter; clear wins, otherwise advance when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc_cnt <= '0;
        end else if (clr) begin
            r_psc_cnt <= '0;
        end else if (en) begin
            r_psc_cnt <= w_match ? '0 : r_psc_cnt + ONE;
        end
    end

endmodule

// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase: up/down counter bounded by the active period.
// Shadowed period/compare commit at wrap when PWM_SHADOW_EN is defined.
module pwm_timebase_ctrl
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cnt_clr,
    input  logic             up_down,
    input  logic [PSC_W-1:0] prescale,
    input  logic             period_wr,
    input  logic [CNT_W-1:0] period_wdata,
    input  logic             cmp1_wr,
    input  logic [CNT_W-1:0] cmp1_wdata,
    input  logic             cmp2_wr,
    input  logic [CNT_W-1:0] cmp2_wdata,
    output logic [CNT_W-1:0] count_val,
    output logic [CNT_W-1:0] period_act,
    output logic [CNT_W-1:0] cmp1_act,
    output logic [CNT_W-1:0] cmp2_act,
    output logic             ovf,
    output logic             upd_pending
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic             w_tick;
    logic             w_wrap;
    cnt_dir_t         w_dir;
    logic [CNT_W-1:0] w_new_per;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per_act;
    logic [CNT_W-1:0] r_cmp1_act;
    logic [CNT_W-1:0] r_cmp2_act;
    logic             r_ovf;
    logic             r_pend;

    pwm_prescaler #(
        .PSC_W(PSC_W)
    ) u_psc (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (cnt_clr),
        .prescale(prescale),
        .tick    (w_tick)
    );

`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0] r_per_sh;
    logic [CNT_W-1:0] r_cmp1_sh;
    logic [CNT_W-1:0] r_cmp2_sh;

    // Period that becomes active at the next commit.
    always_comb w_new_per = r_per_sh;

    // Shadow registers take software writes at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_sh  <= '0;
            r_cmp1_sh <= '0;
            r_cmp2_sh <= '0;
        end else begin
            if (period_wr) r_per_sh  <= period_wdata;
            if (cmp1_wr)   r_cmp1_sh <= cmp1_wdata;
            if (cmp2_wr)   r_cmp2_sh <= cmp2_wdata;
        end
    end

    // Commit pre-write shadows on wrap or clear; a same-cycle write stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_act  <= '0;
            r_cmp1_act <= '0;
            r_cmp2_act <= '0;
            r_pend     <= 1'b0;
        end else begin
            if (cnt_clr || w_wrap) begin
                r_per_act  <= r_per_sh;
                r_cmp1_act <= r_cmp1_sh;
                r_cmp2_act <= r_cmp2_sh;
                r_pend     <= 1'b0;
            end
            if (period_wr || cmp1_wr || cmp2_wr) r_pend <= 1'b1;
        end
    end
`else
    // Without shadowing the active period is the reload value.
    always_comb w_new_per = r_per_act;

    // Writes land directly in the active registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_act  <= '0;
            r_cmp1_act <= '0;
            r_cmp2_act <= '0;
        end else begin
            if (period_wr) r_per_act  <= period_wdata;
            if (cmp1_wr)   r_cmp1_act <= cmp1_wdata;
            if (cmp2_wr)   r_cmp2_act <= cmp2_wdata;
        end
    end

    always_comb r_pend = 1'b0;
`endif

    // Wrap detection and next counter value; clear outranks tick.
    always_comb begin
        w_dir     = cnt_dir_t'(up_down);
        w_wrap    = 1'b0;
        w_cnt_nxt = r_cnt;
        if (cnt_clr) begin
            w_cnt_nxt = (w_dir == DIR_UP) ? '0 : w_new_per;
        end else if (w_tick) begin
            if (w_dir == DIR_UP) begin
                w_wrap    = (r_cnt >= r_per_act);
                w_cnt_nxt = w_wrap ? '0 : r_cnt + ONE;
            end else begin
                w_wrap    = (r_cnt == '0);
                w_cnt_nxt = w_wrap ? w_new_per : r_cnt - ONE;
            end
        end
    end

    // Counter and overflow pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_wrap;
        end
    end

    // Drive the registered values out.
    always_comb begin
        count_val   = r_cnt;
        period_act  = r_per_act;
        cmp1_act    = r_cmp1_act;
        cmp2_act    = r_cmp2_act;
        ovf         = r_ovf;
        upd_pending = r_pend;
    end

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// Self-checking bench for pwm_timebase_ctrl (directed + random, scoreboard).
// Works with or without PWM_SHADOW_EN defined.
module tb_pwm_timebase_ctrl;

    localparam int CW = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n, en, cnt_clr, up_down;
    logic [PW-1:0] prescale;
    logic          period_wr, cmp1_wr, cmp2_wr;
    logic [CW-1:0] period_wdata, cmp1_wdata, cmp2_wdata;
    logic [CW-1:0] count_val, period_act, cmp1_act, cmp2_act;
    logic          ovf, upd_pending;

    pwm_timebase_ctrl #(.CNT_W(CW), .PSC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cnt_clr(cnt_clr),
        .up_down(up_down), .prescale(prescale),
        .period_wr(period_wr), .period_wdata(period_wdata),
        .cmp1_wr(cmp1_wr), .cmp1_wdata(cmp1_wdata),
        .cmp2_wr(cmp2_wr), .cmp2_wdata(cmp2_wdata),
        .count_val(count_val), .period_act(period_act),
        .cmp1_act(cmp1_act), .cmp2_act(cmp2_act),
        .ovf(ovf), .upd_pending(upd_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cnt, pa, c1a, c2a, ps, c1s, c2s;
        logic [PW-1:0] psc;
        logic          pend, ovf;
    } mstate_t;

    typedef struct packed {
        logic [CW-1:0] cnt, pa, c1a, c2a;
        logic          ovf, pend;
    } exp_t;

    mstate_t m;
    exp_t    q[$];
    int      checks = 0;
    int      errors = 0;
    bit      mon_on = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: one clock of the specified behaviour.
    function automatic mstate_t model(input mstate_t s);
        mstate_t n;
        bit tick, wrap, commit;
        logic [CW-1:0] reload;
        n = s;
        n.ovf = 0;
        if (!rst_n) return '0;
        tick = en && (s.psc == prescale);
        if (cnt_clr) n.psc = 0;
        else if (en) n.psc = tick ? 4'd0 : s.psc + 4'd1;
`ifdef PWM_SHADOW_EN
        reload = s.ps;
`else
        reload = s.pa;
`endif
        wrap = 0;
        if (cnt_clr) begin
            n.cnt = up_down ? 8'd0 : reload;
        end else if (tick) begin
            if (up_down) begin
                wrap = (s.cnt >= s.pa);
                n.cnt = wrap ? 8'd0 : s.cnt + 8'd1;
            end else begin
                wrap = (s.cnt == 0);
                n.cnt = wrap ? reload : s.cnt - 8'd1;
            end
        end
        n.ovf = wrap;
        commit = cnt_clr || wrap;
`ifdef PWM_SHADOW_EN
        if (commit) begin
            n.pa = s.ps; n.c1a = s.c1s; n.c2a = s.c2s; n.pend = 0;
        end
        if (period_wr) n.ps  = period_wdata;
        if (cmp1_wr)   n.c1s = cmp1_wdata;
        if (cmp2_wr)   n.c2s = cmp2_wdata;
        if (period_wr || cmp1_wr || cmp2_wr) n.pend = 1;
`else
        if (period_wr) n.pa  = period_wdata;
        if (cmp1_wr)   n.c1a = cmp1_wdata;
        if (cmp2_wr)   n.c2a = cmp2_wdata;
        n.pend = 0;
`endif
        return n;
    endfunction

    // Issue one cycle: model the inputs now driven, queue the expectation.
    task automatic cycle();
        exp_t e;
        m = model(m);
        e = '{cnt: m.cnt, pa: m.pa, c1a: m.c1a, c2a: m.c2a,
              ovf: m.ovf, pend: m.pend};
        q.push_back(e);
        mon_on = 1;
        @(negedge clk);
    endtask

    // Monitor: compare every registered update against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: no expectation queued");
                end else begin
                    e = q.pop_front();
                    if (count_val !== e.cnt || period_act !== e.pa ||
                        cmp1_act !== e.c1a || cmp2_act !== e.c2a ||
                        ovf !== e.ovf || upd_pending !== e.pend) begin
                        errors++;
                        $display("FAIL sb @%0t: got cnt=%0d per=%0d c1=%0d c2=%0d ovf=%0b pend=%0b expected cnt=%0d per=%0d c1=%0d c2=%0d ovf=%0b pend=%0b",
                                 $time, count_val, period_act, cmp1_act, cmp2_act, ovf, upd_pending,
                                 e.cnt, e.pa, e.c1a, e.c2a, e.ovf, e.pend);
                    end
                end
            end
        end
    end

    int up_exp[5]  = '{1, 2, 3, 0, 1};
    int up_ovf[5]  = '{0, 0, 0, 1, 0};
    int dn_exp[5]  = '{2, 1, 0, 3, 2};
    int dn_ovf[5]  = '{0, 0, 0, 1, 0};
    int psc_exp[3] = '{0, 0, 1};
    int mx;

    initial begin
        rst_n = 0; en = 0; cnt_clr = 0; up_down = 1; prescale = 0;
        period_wr = 0; cmp1_wr = 0; cmp2_wr = 0;
        period_wdata = 0; cmp1_wdata = 0; cmp2_wdata = 0;
        m = '0;
        repeat (2) @(negedge clk);
        chk("rst_cnt", count_val, 0);
        chk("rst_per", period_act, 0);
        chk("rst_c1", cmp1_act, 0);
        chk("rst_c2", cmp2_act, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_pend", upd_pending, 0);
        rst_n = 1;

        // Up count, period 3
        period_wr = 1; period_wdata = 3; cycle();
        period_wr = 0; cnt_clr = 1; cycle();
        chk("up_clr", count_val, 0);
        cnt_clr = 0; en = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("up_cnt", count_val, up_exp[i]);
            chk("up_ovf", ovf, up_ovf[i]);
        end

        // Down count, period 3
        up_down = 0; cnt_clr = 1; cycle();
        chk("dn_clr", count_val, 3);
        cnt_clr = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("dn_cnt", count_val, dn_exp[i]);
            chk("dn_ovf", ovf, dn_ovf[i]);
        end

        // Shadow commit of period 5 written at count 1
        up_down = 1; cnt_clr = 1; cycle();
        cnt_clr = 0; cycle();
        period_wr = 1; period_wdata = 5; cycle();
        period_wr = 0;
`ifdef PWM_SHADOW_EN
        chk("sh_per_hold", period_act, 3);
        chk("sh_pend", upd_pending, 1);
`else
        chk("sh_per_direct", period_act, 5);
        chk("sh_pend", upd_pending, 0);
`endif
        mx = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (count_val > mx) mx = count_val;
        end
        chk("sh_max", mx, 5);
        chk("sh_per", period_act, 5);
        chk("sh_pend_clr", upd_pending, 0);

        // Clear coincident with tick at count 2
        cnt_clr = 1; cycle();
        cnt_clr = 0; cycle();
        cmp1_wr = 1; cmp1_wdata = 8'hA5; cycle();
        cmp1_wr = 0;
        chk("cl_pre", count_val, 2);
        cnt_clr = 1; cycle();
        cnt_clr = 0;
        chk("cl_cnt", count_val, 0);
        chk("cl_ovf", ovf, 0);
        chk("cl_c1", cmp1_act, 8'hA5);
        chk("cl_pend", upd_pending, 0);

        // Prescale 2 with enable freeze
        prescale = 2; cnt_clr = 1; cycle();
        cnt_clr = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("psc_cnt", count_val, psc_exp[i]);
        end
        en = 0;
        repeat (4) cycle();
        chk("psc_frz", count_val, 1);
        en = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("psc_resume", count_val, (i == 2) ? 2 : 1);
        end

        // Zero period
        prescale = 0; period_wr = 1; period_wdata = 0; cycle();
        period_wr = 0; cnt_clr = 1; cycle();
        cnt_clr = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("z_cnt", count_val, 0);
            chk("z_ovf", ovf, 1);
        end

        // Reset mid-period at count 4
        period_wr = 1; period_wdata = 7; cycle();
        period_wr = 0; cnt_clr = 1; cycle();
        cnt_clr = 0;
        repeat (4) cycle();
        chk("mr_pre", count_val, 4);
        rst_n = 0;
        #1;
        chk("mr_cnt", count_val, 0);
        chk("mr_per", period_act, 0);
        chk("mr_ovf", ovf, 0);
        chk("mr_pend", upd_pending, 0);
        cycle();
        rst_n = 1;
        cycle();
        chk("mr_restart", count_val, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            en        = ($urandom % 8) != 0;
            cnt_clr   = ($urandom % 40) == 0;
            if ($urandom % 50 == 0) up_down = ~up_down;
            if ($urandom % 60 == 0) prescale = PW'($urandom_range(0, 3));
            period_wr    = ($urandom % 10) == 0;
            period_wdata = CW'($urandom_range(0, 10));
            cmp1_wr      = ($urandom % 10) == 0;
            cmp1_wdata   = CW'($urandom);
            cmp2_wr      = ($urandom % 10) == 0;
            cmp2_wdata   = CW'($urandom);
            rst_n        = ($urandom % 500) != 0;
            cycle();
        end
        rst_n = 1;

        mon_on = 0;
        @(negedge clk);
        chk("sb_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
